// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the round-robin serial pattern matcher.
// Overlapping-match behaviour is selected in seq_detect_sched via SEQ_OVERLAP_EN.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 16;

    // Length field must be able to encode 0..PAT_W inclusive.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    function automatic int ch_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant searching upward from ptr
// with wrap, plus the pointer value to load after a granted transfer.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx,
    output logic            grant_any,
    output logic [CH_W-1:0] ptr_next
);

    logic [CH_W-1:0] idx;

    // Walk from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        ptr_next  = ptr;
        idx       = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = CH_W'((int'(ptr) + k) % N_CH);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
                ptr_next   = CH_W'((int'(idx) + 1) % N_CH);
            end
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// One programmable serial-pattern matcher time-shared across N_CH bit streams.
// Define SEQ_OVERLAP_EN to keep history after a match (overlapping detection).
module seq_detect_sched
    import seq_det_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int LEN_W = len_w(PAT_W),
    parameter int CH_W  = ch_w(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [N_CH-1:0]  w_valid,
    input  logic [N_CH-1:0]  w_bit,
    output logic [N_CH-1:0]  w_ready,
    output logic             z,
    output logic [CH_W-1:0]  z_ch,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    state_t           state_reg, state_next;
    logic [PAT_W-1:0] pattern_reg;
    logic [LEN_W-1:0] len_reg;
    logic [CH_W-1:0]  ptr_reg;
    logic [PAT_W-1:0] hist_reg  [N_CH];
    logic [LEN_W-1:0] fill_reg  [N_CH];
    logic [PAT_W-1:0] hist_next [N_CH];
    logic [LEN_W-1:0] fill_next [N_CH];
    logic [N_CH-1:0]  match_vec;
    logic [PAT_W-1:0] len_mask;
    logic             z_reg;
    logic [CH_W-1:0]  z_ch_reg;
    logic [CNT_W-1:0] match_cnt_reg;

    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  grant;
    logic [CH_W-1:0]  grant_idx;
    logic             grant_any;
    logic [CH_W-1:0]  ptr_next;
    logic             match;

    assign req = (state_reg == RUN) ? w_valid : '0;

    rr_arbiter #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_arb (
        .req       (req),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any),
        .ptr_next  (ptr_next)
    );

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_reg));
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign hist_next[gi] = PAT_W'({hist_reg[gi], w_bit[gi]});
            assign fill_next[gi] = (fill_reg[gi] == LEN_MAX) ? LEN_MAX
                                                             : fill_reg[gi] + LEN_W'(1);
            assign match_vec[gi] = grant[gi] && (fill_next[gi] >= len_reg) &&
                                   (((hist_next[gi] ^ pattern_reg) & len_mask) == '0);
        end
    endgenerate

    assign match = |match_vec;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable) state_next = CLEAR;
            CLEAR:   state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            pattern_reg <= '0;
            len_reg     <= LEN_MAX;
            ptr_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && cfg_we) begin
                pattern_reg <= cfg_pattern;
                if (cfg_len != '0) begin
                    len_reg <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
                end
            end
            if (state_reg == CLEAR) begin
                ptr_reg <= '0;
            end else if (grant_any) begin
                ptr_reg <= ptr_next;
            end
        end
    end

    // Histories only move on their own channel's accepted transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < N_CH; c++) begin
                hist_reg[c] <= '0;
                fill_reg[c] <= '0;
            end
        end else if (state_reg == CLEAR) begin
            for (int c = 0; c < N_CH; c++) begin
                hist_reg[c] <= '0;
                fill_reg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (grant[c]) begin
`ifdef SEQ_OVERLAP_EN
                    hist_reg[c] <= hist_next[c];
                    fill_reg[c] <= fill_next[c];
`else
                    if (match_vec[c]) begin
                        hist_reg[c] <= '0;
                        fill_reg[c] <= '0;
                    end else begin
                        hist_reg[c] <= hist_next[c];
                        fill_reg[c] <= fill_next[c];
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z_reg         <= 1'b0;
            z_ch_reg      <= '0;
            match_cnt_reg <= '0;
        end else begin
            z_reg <= match;
            if (match) begin
                z_ch_reg <= grant_idx;
            end
            if (state_reg == CLEAR) begin
                match_cnt_reg <= '0;
            end else if (match && match_cnt_reg != '1) begin
                match_cnt_reg <= match_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign w_ready   = grant;
    assign z         = z_reg;
    assign z_ch      = z_ch_reg;
    assign match_cnt = match_cnt_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched (4 channels, 8-bit pattern, 2-bit counter).
// Expectations follow SEQ_OVERLAP_EN when it is defined for the build.
module tb_seq_detect_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [3:0] w_valid;
    logic [3:0] w_bit;
    logic [3:0] w_ready;
    logic       z;
    logic [1:0] z_ch;
    logic [1:0] match_cnt;
    logic       busy;

    always #5 clk = ~clk;

    seq_detect_sched #(
        .N_CH  (4),
        .PAT_W (8),
        .CNT_W (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .w_valid     (w_valid),
        .w_bit       (w_bit),
        .w_ready     (w_ready),
        .z           (z),
        .z_ch        (z_ch),
        .match_cnt   (match_cnt),
        .busy        (busy)
    );

    typedef struct packed {
        logic       z;
        logic [1:0] ch;
        logic [1:0] cnt;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: 0 = idle, 1 = clear, 2 = run
    int         m_state;
    logic [7:0] m_pat;
    int         m_len;
    int         m_ptr;
    int         m_cnt;
    logic [7:0] m_hist [4];
    int         m_fill [4];

    task automatic model_reset();
        m_state = 0; m_pat = '0; m_len = 8; m_ptr = 0; m_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            m_hist[c] = '0;
            m_fill[c] = 0;
        end
        sb.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies one cycle of inputs, advances the model and queues the post-edge outputs.
    task automatic drive(input logic en, input logic [3:0] vld, input logic [3:0] bits,
                         input logic we, input logic [7:0] pat, input logic [3:0] len,
                         output logic [3:0] g_exp);
        exp_t       e;
        int         ch;
        logic [1:0] ci;
        logic [1:0] pi;
        logic       hit;
        logic [7:0] mask;
        enable = en; w_valid = vld; w_bit = bits; cfg_we = we; cfg_pattern = pat; cfg_len = len;
        #1;
        g_exp = '0; ch = -1; ci = '0; hit = 1'b0;
        if (m_state == 2) begin
            for (int k = 0; k < 4; k++) begin
                pi = 2'((m_ptr + k) % 4);
                if (ch < 0 && vld[pi]) ch = int'(pi);
            end
        end
        if (ch >= 0) begin
            ci = 2'(ch);
            g_exp[ci] = 1'b1;
            m_hist[ci] = {m_hist[ci][6:0], bits[ci]};
            if (m_fill[ci] < 8) m_fill[ci]++;
            mask = 8'((1 << m_len) - 1);
            hit = (m_fill[ci] >= m_len) && ((m_hist[ci] & mask) == (m_pat & mask));
            if (hit) begin
                if (m_cnt < 3) m_cnt++;
`ifndef SEQ_OVERLAP_EN
                m_hist[ci] = '0;
                m_fill[ci] = 0;
`endif
            end
            m_ptr = (ch + 1) % 4;
            $display("xfer ch=%0d bit=%b hit=%b cnt=%0d", ch, bits[ci], hit, m_cnt);
        end
        if (m_state == 0 && we) begin
            m_pat = pat;
            if (len != 0) m_len = (len > 8) ? 8 : int'(len);
        end else if (m_state == 1) begin
            for (int c = 0; c < 4; c++) begin
                m_hist[c] = '0;
                m_fill[c] = 0;
            end
            m_cnt = 0;
            m_ptr = 0;
        end
        case (m_state)
            0:       m_state = en ? 1 : 0;
            1:       m_state = 2;
            default: m_state = en ? 2 : 0;
        endcase
        e.z = hit; e.ch = ci; e.cnt = 2'(m_cnt); e.busy = (m_state != 0);
        sb.push_back(e);
    endtask

    task automatic setup(input logic en, input logic we, input logic [7:0] pat, input logic [3:0] len);
        logic [3:0] g;
        exp_t       d;
        drive(en, 4'h0, 4'h0, we, pat, len, g);
        tick();
        d = sb.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
        w_valid = 4'hF; w_bit = 4'h0;
        #2;
        n_vec++; if (z !== 1'b0) begin n_bad++; $display("FAIL reset_z: got %b want 0", z); end
        n_vec++; if (match_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (w_ready !== 4'h0) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", w_ready); end
        tick();
        tick();
        reset = 1'b1;
        w_valid = 4'h0;
        model_reset();
    endtask

    task automatic test_basic_match();
        logic [3:0] g;
        exp_t       e;
        logic [7:0] zm;
        logic [7:0] bs;
        setup(1'b0, 1'b1, 8'h0B, 4'd4);
        setup(1'b1, 1'b0, 8'h00, 4'd0);
        // cycle 0 is the CLEAR cycle; enable drops together with the 7th bit
        bs = 8'b1101_1011;
        zm = '0;
        for (int i = 0; i < 8; i++) begin
            drive(i != 7, 4'b0001, {3'b000, bs[i]}, 1'b0, 8'h00, 4'd0, g);
            n_vec++; if (w_ready !== g) begin n_bad++; $display("FAIL basic_grant[%0d]: got %b want %b", i, w_ready, g); end
            tick();
            e = sb.pop_front();
            zm[i] = z;
            n_vec++;
            if (z !== e.z || (e.z && z_ch !== e.ch) || match_cnt !== e.cnt || busy !== e.busy) begin
                n_bad++;
                $display("FAIL basic_out[%0d]: got z=%b ch=%0d cnt=%0d busy=%b want z=%b ch=%0d cnt=%0d busy=%b",
                         i, z, z_ch, match_cnt, busy, e.z, e.ch, e.cnt, e.busy);
            end
        end
`ifdef SEQ_OVERLAP_EN
        n_vec++; if (zm !== 8'b1001_0000) begin n_bad++; $display("FAIL basic_zmask: got %b want 10010000", zm); end
        n_vec++; if (match_cnt !== 2'd2) begin n_bad++; $display("FAIL basic_cnt: got %0d want 2", match_cnt); end
`else
        n_vec++; if (zm !== 8'b0001_0000) begin n_bad++; $display("FAIL basic_zmask: got %b want 00010000", zm); end
        n_vec++; if (match_cnt !== 2'd1) begin n_bad++; $display("FAIL basic_cnt: got %0d want 1", match_cnt); end
`endif
    endtask

    task automatic test_fairness();
        logic [3:0] g;
        exp_t       e;
        logic [3:0] want [5];
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        setup(1'b1, 1'b0, 8'h00, 4'd0);
        setup(1'b1, 1'b0, 8'h00, 4'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'hF, 4'h0, 1'b0, 8'h00, 4'd0, g);
            n_vec++;
            if (w_ready !== want[i] || w_ready !== g) begin
                n_bad++; $display("FAIL fair_grant[%0d]: got %b want %b", i, w_ready, want[i]);
            end
            tick();
            e = sb.pop_front();
            n_vec++;
            if (z !== e.z || match_cnt !== e.cnt || busy !== e.busy) begin
                n_bad++; $display("FAIL fair_out[%0d]: got z=%b cnt=%0d busy=%b want z=%b cnt=%0d busy=%b",
                                  i, z, match_cnt, busy, e.z, e.cnt, e.busy);
            end
        end
        setup(1'b0, 1'b0, 8'h00, 4'd0);
    endtask

    task automatic test_config_gating();
        logic [3:0] g;
        exp_t       e;
        logic [7:0] zm;
        logic [3:0] bs;
        setup(1'b0, 1'b1, 8'h0B, 4'd4);
        setup(1'b1, 1'b0, 8'h00, 4'd0);
        setup(1'b1, 1'b0, 8'h00, 4'd0);
        // Index 0 attempts a config write while running; indices 1..4 send 1,0,1,1.
        bs = 4'b1101;
        zm = '0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1'b1, 4'b0000, 4'h0, 1'b1, 8'hFF, 4'd8, g);
            else        drive(1'b1, 4'b0001, {3'b000, bs[i-1]}, 1'b0, 8'h00, 4'd0, g);
            n_vec++; if (w_ready !== g) begin n_bad++; $display("FAIL cfg_run_grant[%0d]: got %b want %b", i, w_ready, g); end
            tick();
            e = sb.pop_front();
            zm[i] = z;
            n_vec++;
            if (z !== e.z || (e.z && z_ch !== e.ch) || match_cnt !== e.cnt) begin
                n_bad++; $display("FAIL cfg_run_out[%0d]: got z=%b cnt=%0d want z=%b cnt=%0d", i, z, match_cnt, e.z, e.cnt);
            end
        end
        n_vec++; if (zm !== 8'b0001_0000) begin n_bad++; $display("FAIL cfg_run_ignored: got %b want 00010000", zm); end
        setup(1'b0, 1'b0, 8'h00, 4'd0);
        // Zero length leaves len at 4; then 9 clamps to 8.
        for (int pass = 0; pass < 2; pass++) begin
            setup(1'b0, 1'b1, 8'h00, (pass == 0) ? 4'd0 : 4'd9);
            setup(1'b1, 1'b0, 8'h00, 4'd0);
            setup(1'b1, 1'b0, 8'h00, 4'd0);
            zm = '0;
            for (int i = 0; i < ((pass == 0) ? 4 : 8); i++) begin
                drive(1'b1, 4'b1000, 4'b0000, 1'b0, 8'h00, 4'd0, g);
                n_vec++; if (w_ready !== g) begin n_bad++; $display("FAIL cfg_len_grant[%0d]: got %b want %b", i, w_ready, g); end
                tick();
                e = sb.pop_front();
                zm[i] = z;
                n_vec++;
                if (z !== e.z || (e.z && z_ch !== e.ch) || match_cnt !== e.cnt) begin
                    n_bad++; $display("FAIL cfg_len_out[%0d]: got z=%b ch=%0d cnt=%0d want z=%b ch=%0d cnt=%0d",
                                      i, z, z_ch, match_cnt, e.z, e.ch, e.cnt);
                end
            end
            n_vec++;
            if (zm !== ((pass == 0) ? 8'b0000_1000 : 8'b1000_0000)) begin
                n_bad++; $display("FAIL cfg_len_pass%0d: got zmask %b", pass, zm);
            end
            setup(1'b0, 1'b0, 8'h00, 4'd0);
        end
    endtask

    task automatic test_fill_guard();
        logic [3:0] g;
        exp_t       e;
        logic [2:0] zm;
        setup(1'b0, 1'b1, 8'h00, 4'd3);
        setup(1'b1, 1'b0, 8'h00, 4'd0);
        setup(1'b1, 1'b0, 8'h00, 4'd0);
        zm = '0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b0100, 4'b0000, 1'b0, 8'h00, 4'd0, g);
            n_vec++; if (w_ready !== g) begin n_bad++; $display("FAIL fill_grant[%0d]: got %b want %b", i, w_ready, g); end
            tick();
            e = sb.pop_front();
            zm[i] = z;
            n_vec++;
            if (z !== e.z || (e.z && z_ch !== e.ch) || match_cnt !== e.cnt) begin
                n_bad++; $display("FAIL fill_out[%0d]: got z=%b ch=%0d cnt=%0d want z=%b ch=%0d cnt=%0d",
                                  i, z, z_ch, match_cnt, e.z, e.ch, e.cnt);
            end
        end
        n_vec++; if (zm !== 3'b100 || z_ch !== 2'd2) begin n_bad++; $display("FAIL fill_guard: got zmask %b ch=%0d want 100 ch=2", zm, z_ch); end
        setup(1'b0, 1'b0, 8'h00, 4'd0);
    endtask

    task automatic test_saturation();
        logic [3:0] g;
        exp_t       e;
        int         zc;
        setup(1'b0, 1'b1, 8'h01, 4'd1);
        setup(1'b1, 1'b0, 8'h00, 4'd0);
        setup(1'b1, 1'b0, 8'h00, 4'd0);
        zc = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0010, 4'b0010, 1'b0, 8'h00, 4'd0, g);
            n_vec++; if (w_ready !== g) begin n_bad++; $display("FAIL sat_grant[%0d]: got %b want %b", i, w_ready, g); end
            tick();
            e = sb.pop_front();
            if (z === 1'b1 && z_ch === 2'd1) zc++;
            n_vec++;
            if (z !== e.z || (e.z && z_ch !== e.ch) || match_cnt !== e.cnt) begin
                n_bad++; $display("FAIL sat_out[%0d]: got z=%b ch=%0d cnt=%0d want z=%b ch=%0d cnt=%0d",
                                  i, z, z_ch, match_cnt, e.z, e.ch, e.cnt);
            end
        end
        n_vec++; if (zc != 5) begin n_bad++; $display("FAIL sat_pulses: got %0d want 5", zc); end
        n_vec++; if (match_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_cnt: got %0d want 3", match_cnt); end
        setup(1'b0, 1'b0, 8'h00, 4'd0);
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] g;
        exp_t       e;
        setup(1'b0, 1'b1, 8'h01, 4'd1);
        setup(1'b1, 1'b0, 8'h00, 4'd0);
        setup(1'b1, 1'b0, 8'h00, 4'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'b0001, 4'b0001, 1'b0, 8'h00, 4'd0, g);
            n_vec++; if (w_ready !== g) begin n_bad++; $display("FAIL rst_grant[%0d]: got %b want %b", i, w_ready, g); end
            tick();
            e = sb.pop_front();
            n_vec++;
            if (z !== e.z || match_cnt !== e.cnt || busy !== e.busy) begin
                n_bad++; $display("FAIL rst_pre[%0d]: got z=%b cnt=%0d busy=%b want z=%b cnt=%0d busy=%b",
                                  i, z, match_cnt, busy, e.z, e.cnt, e.busy);
            end
        end
        #3;
        reset = 1'b0;
        #1;
        n_vec++; if (z !== 1'b0) begin n_bad++; $display("FAIL rst_mid_z: got %b want 0", z); end
        n_vec++; if (match_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_mid_cnt: got %0d want 0", match_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_vec++; if (w_ready !== 4'h0) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 0000", w_ready); end
        tick();
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'hF, 4'hF, 1'b0, 8'h00, 4'd0, g);
            n_vec++; if (w_ready !== g) begin n_bad++; $display("FAIL rst_idle_grant[%0d]: got %b want %b", i, w_ready, g); end
            tick();
            e = sb.pop_front();
            n_vec++;
            if (z !== e.z || match_cnt !== e.cnt || busy !== e.busy) begin
                n_bad++; $display("FAIL rst_idle_out[%0d]: got z=%b cnt=%0d busy=%b want z=%b cnt=%0d busy=%b",
                                  i, z, match_cnt, busy, e.z, e.cnt, e.busy);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_match();
        test_fairness();
        test_config_gating();
        test_fill_guard();
        test_saturation();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Round-robin scheduler that shares one programmable serial-pattern matcher among N_CH independent bit streams. Each stream offers one bit per transfer over a valid/ready handshake. The block keeps a per-channel history register, compares it against a runtime-configured pattern and length, and pulses a match flag tagged with the channel id. It sits between the serial input sources and the downstream event logic, and replaces one hard-coded sequence detector per stream.

## Interface
- N_CH, 4: number of requesting streams (≥2).
- PAT_W, 8: maximum pattern length in bits.
- CNT_W, 16: width of the saturating match counter.
- LEN_W, derived $clog2(PAT_W+1): width of the length field.
- clk  in  1  clock; all flops rise-edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request; level-sensitive.
- cfg_we  in  1  config write strobe; honoured only in IDLE.
- cfg_pattern  in  PAT_W  pattern; bit 0 = most recent bit.
- cfg_len  in  LEN_W  pattern length.
- w_valid  in  N_CH  per-channel bit valid.
- w_bit  in  N_CH  per-channel serial bit.
- w_ready  out  N_CH  one-hot grant/accept.
- z  out  1  one-cycle match pulse.
- z_ch  out  $clog2(N_CH)  channel that matched; valid when z=1.
- match_cnt  out  CNT_W  total matches since last CLEAR, saturating.
- busy  out  1  high when state ≠ IDLE.

## Operation
- FSM states: IDLE, CLEAR, RUN.
  - IDLE → CLEAR when enable=1.
  - CLEAR → RUN unconditionally after 1 cycle.
  - RUN → IDLE when enable=0.
- IDLE:
  - cfg_we=1 latches cfg_pattern.
  - cfg_len=0 is ignored and the length register holds its value.
  - cfg_len>PAT_W is clamped to PAT_W.
  - cfg_we outside IDLE is ignored.
- CLEAR: zeroes all histories, fill counters and match_cnt. Also resets the round-robin pointer to 0.
- RUN arbitration:
  - Grant goes to the first channel with w_valid=1, searching from the pointer upward with wrap.
  - w_ready is combinational and one-hot for that channel only; it is 0 in IDLE and CLEAR.
  - On a transfer (w_valid & w_ready), the pointer becomes grant+1 mod N_CH. With no request, the pointer holds.
- Per transfer on channel c:
  - hist[c] ← {hist[c][PAT_W-2:0], w_bit[c]}.
  - fill[c] increments, saturating at PAT_W.
- Match condition: fill[c] (after increment) ≥ len, and the low len bits of the new hist equal the low len bits of the pattern.
- On match: z=1, z_ch=c; match_cnt increments, saturating at 2^CNT_W−1.
- Leaving RUN freezes histories; they are discarded on the next CLEAR.

## Timing
- Reset values: z=0, z_ch=0, match_cnt=0, w_ready=0, busy=0. State=IDLE, pattern=0, len=PAT_W, pointer=0, all hist/fill=0.
- z, z_ch and match_cnt are registered. z is high exactly one cycle, in the cycle after the accepting edge (latency 1).
- At most one transfer per cycle, so at most one z per cycle.
- busy is high from the first cycle of CLEAR through the last cycle of RUN.
- If enable drops in the same cycle as a transfer, that transfer completes and its match still pulses z in the next cycle.
- Reset asserted mid-RUN clears everything immediately, regardless of clk.

## Configuration
- SEQ_OVERLAP_EN defined: after a match, hist[c] and fill[c] are kept, so overlapping occurrences are detected.
- SEQ_OVERLAP_EN undefined: on a match, hist[c] and fill[c] are cleared to 0. The next match then requires len fresh bits.

## Structure
- Package seq_det_pkg holds:
  - the state enum (IDLE, CLEAR, RUN);
  - the LEN_W/CH_W width helper functions;
  - the default parameter constants.
- Sub-module rr_arbiter (N_CH) produces the one-hot grant from the request vector and pointer, and the next pointer.
- Histories, fill counters and compare logic stay in seq_detect_sched.

## Test plan
- Basic match, with pattern=0x0B and len=4:
  - Stimulus: enable; ch0 sends 1,0,1,1,0,1,1.
  - With SEQ_OVERLAP_EN: z pulses with z_ch=0 after the 4th and 7th bits, and match_cnt=2.
  - Without SEQ_OVERLAP_EN: only the 4th bit matches, and match_cnt=1.
- Fairness: all 4 channels hold w_valid=1 → the w_ready grant sequence is ch0, ch1, ch2, ch3, ch0 on consecutive cycles.
- Config gating:
  - cfg_we in RUN with pattern=0xFF → no effect.
  - cfg_we in IDLE with cfg_len=0 → len unchanged.
  - cfg_we in IDLE with cfg_len=9 → len=8.
- Saturation: CNT_W=2, pattern=0x01, len=1, ch1 sends five 1s → match_cnt=3, and z pulses 5 times with z_ch=1.
- Reset mid-RUN: assert reset between clock edges after 2 matches → z=0, match_cnt=0, busy=0 immediately. After release, IDLE persists until enable.
- Fill guard: after CLEAR with pattern=0x00 and len=3, ch2 sends 0,0 → no z. A third 0 → z=1 with z_ch=2.
